unfilter_line: RTL and testbench

// PNG decode-side scanline reconstruction: inverse of the encoder's filter stage.

---
 rtl/unfilter_pkg.sv | 17 +
 rtl/unfilter_pred.sv | 56 +++++
 rtl/unfilter_line.sv | 208 ++++++++++++++++++++
 tb/tb_unfilter_line.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unfilter_pkg.sv
// Shared constants and types for PNG scanline reconstruction.
package unfilter_pkg;

  localparam logic [2:0] FILT_NONE  = 3'd0;
  localparam logic [2:0] FILT_SUB   = 3'd1;
  localparam logic [2:0] FILT_UP    = 3'd2;
  localparam logic [2:0] FILT_AVG   = 3'd3;
  localparam logic [2:0] FILT_PAETH = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StType,
    StData,
    StFlush
  } state_e;

endpackage

// File: rtl/unfilter_pred.sv
// Combinational PNG predictor: recon = filt + pred(type, a, b, c) modulo 2^DATA_WD.
module unfilter_pred
  import unfilter_pkg::*;
#(
  parameter int unsigned DATA_WD = 8
) (
  input  logic [2:0]         ftype_i,
  input  logic [DATA_WD-1:0] a_i,
  input  logic [DATA_WD-1:0] b_i,
  input  logic [DATA_WD-1:0] c_i,
  input  logic [DATA_WD-1:0] filt_i,
  output logic [DATA_WD-1:0] recon_o
);

  localparam int unsigned SW = DATA_WD + 2;

  logic [DATA_WD:0]        avg_sum;
  logic signed [SW-1:0]    sa, sb, sc;
  logic signed [SW-1:0]    pa, pb, pc;
  logic [DATA_WD-1:0]      paeth;
  logic [DATA_WD-1:0]      pred;

  function automatic logic signed [SW-1:0] abs_s(input logic signed [SW-1:0] v);
    return v[SW-1] ? -v : v;
  endfunction

  always_comb begin
    // Two guard bits keep a+b-2c (range +-2*(2^DATA_WD-1)) sign-correct.
    avg_sum = {1'b0, a_i} + {1'b0, b_i};
    sa      = $signed({2'b00, a_i});
    sb      = $signed({2'b00, b_i});
    sc      = $signed({2'b00, c_i});
    pa      = abs_s(sb - sc);
    pb      = abs_s(sa - sc);
    pc      = abs_s(sa + sb - sc - sc);

    if ((pa <= pb) && (pa <= pc)) begin
      paeth = a_i;
    end else if (pb <= pc) begin
      paeth = b_i;
    end else begin
      paeth = c_i;
    end

    case (ftype_i)
      FILT_SUB:   pred = a_i;
      FILT_UP:    pred = b_i;
      FILT_AVG:   pred = avg_sum[DATA_WD:1];
      FILT_PAETH: pred = paeth;
      default:    pred = '0;
    endcase

    recon_o = filt_i + pred;
  end

endmodule

// File: rtl/unfilter_line.sv
// PNG decode-side scanline un-filter: type byte + line_len_i data bytes per line in,
// reconstructed bytes out through a one-deep output register, prior line kept in RAM.
module unfilter_line
  import unfilter_pkg::*;
#(
  parameter int unsigned DATA_WD  = 8,
  parameter int unsigned BPP_MAX  = 8,
  parameter int unsigned LINE_MAX = 8192,
  parameter int unsigned LINE_AW  = 13
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [LINE_AW-1:0] line_len_i,
  input  logic [15:0]        line_num_i,
  input  logic [3:0]         bpp_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic               last_o,
  input  logic               rdy_i,
  output logic               err_o,
  output logic               done_o
);

  localparam int unsigned BppAw = (BPP_MAX > 1) ? $clog2(BPP_MAX) : 1;

  state_e             state_q, state_d;
  logic [LINE_AW-1:0] len_q, len_d;
  logic [LINE_AW-1:0] x_q, x_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        line_q, line_d;
  logic [3:0]         bpp_q, bpp_d;
  logic [2:0]         ftype_q, ftype_d;
  logic               first_q, first_d;
  logic [DATA_WD-1:0] recon_sr_q [BPP_MAX];
  logic [DATA_WD-1:0] recon_sr_d [BPP_MAX];
  logic [DATA_WD-1:0] prior_sr_q [BPP_MAX];
  logic [DATA_WD-1:0] prior_sr_d [BPP_MAX];
  logic               val_q, val_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [DATA_WD-1:0] mem_q [LINE_MAX];

  logic               in_fire, out_fire, type_fire, data_fire;
  logic               line_end, last_line, type_bad;
  logic [BppAw-1:0]   tap;
  logic [DATA_WD-1:0] a, b, c, recon;

  assign rdy_o     = (state_q != StIdle) & (~val_q | rdy_i);
  assign in_fire   = val_i & rdy_o;
  assign out_fire  = val_q & rdy_i;
  assign type_fire = in_fire & (state_q == StType);
  assign data_fire = in_fire & (state_q == StData);
  assign line_end  = (x_q == len_q - LINE_AW'(1));
  assign last_line = (line_q == num_q - 16'd1);
  assign type_bad  = (dat_i > DATA_WD'(FILT_PAETH));

  // Shift registers are zeroed at line start, so x < bpp naturally yields a = c = 0.
  assign tap = BppAw'(bpp_q - 4'd1);
  assign a   = recon_sr_q[tap];
  assign c   = prior_sr_q[tap];
  assign b   = first_q ? '0 : mem_q[x_q];

  unfilter_pred #(
    .DATA_WD (DATA_WD)
  ) u_pred (
    .ftype_i (ftype_q),
    .a_i     (a),
    .b_i     (b),
    .c_i     (c),
    .filt_i  (dat_i),
    .recon_o (recon)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    x_d        = x_q;
    num_d      = num_q;
    line_d     = line_q;
    bpp_d      = bpp_q;
    ftype_d    = ftype_q;
    first_d    = first_q;
    recon_sr_d = recon_sr_q;
    prior_sr_d = prior_sr_q;
    val_d      = val_q;
    dat_d      = dat_q;
    last_d     = last_q;
    err_d      = 1'b0;
    done_d     = 1'b0;

    if (out_fire) begin
      val_d  = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = line_len_i;
          num_d   = line_num_i;
          bpp_d   = bpp_i;
          x_d     = '0;
          line_d  = '0;
          first_d = 1'b1;
          state_d = StType;
        end
      end
      StType: begin
        if (type_fire) begin
          ftype_d = type_bad ? FILT_NONE : dat_i[2:0];
          err_d   = type_bad;
          x_d     = '0;
          for (int i = 0; i < BPP_MAX; i++) begin
            recon_sr_d[i] = '0;
            prior_sr_d[i] = '0;
          end
          state_d = StData;
        end
      end
      StData: begin
        if (data_fire) begin
          val_d         = 1'b1;
          dat_d         = recon;
          last_d        = line_end;
          recon_sr_d[0] = recon;
          prior_sr_d[0] = b;
          for (int i = 1; i < BPP_MAX; i++) begin
            recon_sr_d[i] = recon_sr_q[i-1];
            prior_sr_d[i] = prior_sr_q[i-1];
          end
          if (line_end) begin
            x_d     = '0;
            first_d = 1'b0;
            line_d  = line_q + 16'd1;
            state_d = last_line ? StFlush : StType;
          end else begin
            x_d = x_q + LINE_AW'(1);
          end
        end
      end
      StFlush: begin
        // The output register holds the image's final byte until it is taken.
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      x_q        <= '0;
      num_q      <= '0;
      line_q     <= '0;
      bpp_q      <= '0;
      ftype_q    <= FILT_NONE;
      first_q    <= 1'b1;
      recon_sr_q <= '{default: '0};
      prior_sr_q <= '{default: '0};
      val_q      <= 1'b0;
      dat_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      x_q        <= x_d;
      num_q      <= num_d;
      line_q     <= line_d;
      bpp_q      <= bpp_d;
      ftype_q    <= ftype_d;
      first_q    <= first_d;
      recon_sr_q <= recon_sr_d;
      prior_sr_q <= prior_sr_d;
      val_q      <= val_d;
      dat_q      <= dat_d;
      last_q     <= last_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Prior-line RAM: read of mem_q[x_q] above sees the old line; write lands at the edge.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      mem_q[x_q] <= recon;
    end
  end

  assign val_o  = val_q;
  assign dat_o  = dat_q;
  assign last_o = last_q;
  assign err_o  = err_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_unfilter_line.sv
// Directed bench for unfilter_line: hand-computed vectors, scoreboard on accepted outputs.
module tb_unfilter_line;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [12:0] line_len_i = '0;
  logic [15:0] line_num_i = '0;
  logic [3:0]  bpp_i = '0;
  logic        val_i = 1'b0;
  logic [7:0]  dat_i = '0;
  logic        rdy_o;
  logic        val_o;
  logic [7:0]  dat_o;
  logic        last_o;
  logic        rdy_i = 1'b1;
  logic        err_o;
  logic        done_o;

  typedef struct packed {
    logic       last;
    logic [7:0] d;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] gold_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic rnd_mode = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] dat_prev = '0;
  logic last_prev = 1'b0;

  unfilter_line u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .line_len_i (line_len_i),
    .line_num_i (line_num_i),
    .bpp_i      (bpp_i),
    .val_i      (val_i),
    .dat_i      (dat_i),
    .rdy_o      (rdy_o),
    .val_o      (val_o),
    .dat_o      (dat_o),
    .last_o     (last_o),
    .rdy_i      (rdy_i),
    .err_o      (err_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard on every accepted byte, stability check while stalled.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_val", val_o, 1);
        check_eq("hold_dat", dat_o, dat_prev);
        check_eq("hold_last", last_o, last_prev);
      end
      if (val_o && rdy_i) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", val_o, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("out_dat", dat_o, e.d);
          check_eq("out_last", last_o, e.last);
        end
      end
      stall_prev = val_o && !rdy_i;
      dat_prev   = dat_o;
      last_prev  = last_o;
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    val_i = 1'b1;
    dat_i = b;
    @(negedge clk);
    while (!rdy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rdy_o) check_eq("send_timeout", rdy_o, 1);
    @(posedge clk);
    #1;
    val_i = 1'b0;
  endtask

  task automatic start_image(input int bpp, input int len, input int nlines);
    bpp_i      = 4'(bpp);
    line_len_i = 13'(len);
    line_num_i = 16'(nlines);
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_line(input int len);
    exp_t e;
    send_byte(stim_q.pop_front());
    for (int x = 0; x < len; x++) begin
      e.last = (x == len - 1);
      e.d    = gold_q.pop_front();
      sb_q.push_back(e);
      send_byte(stim_q.pop_front());
    end
  endtask

  task automatic run_image(input int bpp, input int len, input int nlines, input int n_err);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    start_image(bpp, len, nlines);
    for (int l = 0; l < nlines; l++) send_line(len);
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    check_eq("done_once", done_cnt - d0, 1);
    check_eq("err_pulses", err_cnt - e0, n_err);
    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("idle_rdy", rdy_o, 0);
  endtask

  task automatic load_sub_up();
    stim_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01};
    gold_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h03, 8'h04, 8'h05};
  endtask

  // Paeth line: x0..2 pick b (pb=0); x3,x4 pick b (pb=1); x5 picks a (pa=pb=255).
  task automatic load_paeth();
    stim_q = '{8'h00, 8'h64, 8'hc8, 8'hff, 8'h00, 8'h00, 8'h00,
               8'h04, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    gold_q = '{8'h64, 8'hc8, 8'hff, 8'h00, 8'h00, 8'h00,
               8'h65, 8'hc9, 8'h00, 8'h01, 8'h01, 8'h01};
  endtask

  initial begin
    #12;
    check_eq("rst_val", val_o, 0);
    check_eq("rst_rdy", rdy_o, 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_last", last_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_done", done_o, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("idle_rdy_after_rst", rdy_o, 0);

    // None filter, single line
    stim_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
    gold_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_image(1, 4, 1, 0);

    // Sub then Up
    load_sub_up();
    run_image(1, 4, 2, 0);

    // Paeth, bpp=3
    load_paeth();
    run_image(3, 6, 2, 0);

    // Avg: x1 needs the 9-bit sum (7f+ff)>>1 = bf
    stim_q = '{8'h00, 8'hff, 8'hff, 8'h03, 8'h00, 8'h00};
    gold_q = '{8'hff, 8'hff, 8'h7f, 8'hbf};
    run_image(1, 2, 2, 0);

    // Illegal type byte decodes as None and flags err_o once
    stim_q = '{8'h07, 8'h05, 8'h06};
    gold_q = '{8'h05, 8'h06};
    run_image(1, 2, 1, 1);

    // Same vectors under random backpressure
    rnd_mode = 1'b1;
    load_sub_up();
    run_image(1, 4, 2, 0);
    load_paeth();
    run_image(3, 6, 2, 0);
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of the second line
    load_sub_up();
    start_image(1, 4, 2);
    send_line(4);
    send_byte(stim_q.pop_front());
    for (int x = 0; x < 2; x++) begin
      exp_t e;
      e.last = 1'b0;
      e.d    = gold_q.pop_front();
      sb_q.push_back(e);
      send_byte(stim_q.pop_front());
    end
    rstn = 1'b0;
    @(negedge clk);
    check_eq("midrst_val", val_o, 0);
    check_eq("midrst_rdy", rdy_o, 0);
    check_eq("midrst_last", last_o, 0);
    sb_q.delete();
    stim_q.delete();
    gold_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("postrst_rdy", rdy_o, 0);

    // Fresh image: Up on line 0 must ignore stale RAM; Sub with bpp=2
    stim_q = '{8'h02, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    gold_q = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 8'h02, 8'h04, 8'h06};
    @(posedge clk);
    #1;
    run_image(2, 4, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", n_chk);
    $fatal(1);
  end

endmodule
